capture_buffer: RTL and testbench

Sample store and readout stage directly downstream of `sampler` in the logic-analyser path. Consumes the sampler's per-sample write stream (`Q`, `addrq`, `wren`, `trigger`) and writes it into a circular on-chip RAM. It holds off the trigger until enough pre-trigger history exists, then records a fixed post-trigger window and freezes. It then streams the full window, oldest sample first, over a valid/ready interface to the host-link stage.

---
 rtl/la_pkg.sv | 23 ++
 rtl/capture_ram.sv | 25 ++
 rtl/capture_buffer.sv | 136 +++++++++++++
 tb/tb_capture_buffer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyser capture path: FSM states,
// sampler trigger encodings and default capture geometry.
package la_pkg;

  localparam int DEF_ADDR_WIDTH = 10;
  localparam int DEF_DEPTH      = 1 << DEF_ADDR_WIDTH;
  localparam int DEF_POST_TRIG  = 512;

  typedef enum logic [1:0] {
    IDLE,
    PRE,
    POST,
    READ
  } cap_state_e;

  typedef enum logic [1:0] {
    TRIG_NONE,
    TRIG_LEVEL,
    TRIG_RISE,
    TRIG_FALL
  } trig_kind_e;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample RAM: one write port, one synchronous read port
// with registered, enable-held read data (block RAM template).
module capture_ram #(
  parameter int BUS_WIDTH  = 1,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [BUS_WIDTH-1:0]  wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [BUS_WIDTH-1:0]  rdata
);

  logic [BUS_WIDTH-1:0] mem [1 << ADDR_WIDTH];

  // NOTE: no reset on the array or read register; a reset here would
  // prevent mapping onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/capture_buffer.sv
// Circular pre/post-trigger sample capture with oldest-first valid/ready
// readout through a RAM-latency pipeline and registered output stage.
module capture_buffer
  import la_pkg::*;
#(
  parameter int BUS_WIDTH  = 1,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int POST_TRIG  = DEF_POST_TRIG
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arm,
  input  logic [BUS_WIDTH-1:0]  Q,
  input  logic [ADDR_WIDTH-1:0] addrq,
  input  logic                  wren,
  input  logic                  trigger,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] trig_addr,
  output logic [BUS_WIDTH-1:0]  rd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  rd_last
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] FILL_THR = CW'(DEPTH - POST_TRIG);
  localparam logic [CW-1:0] POST_END = CW'(POST_TRIG - 1);

  cap_state_e            state, state_nxt;
  logic [CW-1:0]         fill_cnt, post_cnt, rd_cnt;
  logic [ADDR_WIDTH-1:0] last_addr, rd_ptr;
  logic [BUS_WIDTH-1:0]  ram_q;
  logic                  mid_valid, mid_last;
  logic                  trig_ok, post_end, rd_fire, out_load, issue, ram_we;

  // Middle stage holds the RAM read data; a new read is issued only when
  // that slot is empty or drains into the output register this cycle.
  always_comb begin
    trig_ok  = (state == PRE) && wren && trigger && (fill_cnt >= FILL_THR);
    post_end = (state == POST) && wren && (post_cnt == POST_END);
    rd_fire  = rd_valid && rd_ready;
    out_load = mid_valid && (!rd_valid || rd_ready);
    issue    = (state == READ) && (rd_cnt != DEPTH_C) && (!mid_valid || out_load);
    ram_we   = wren && ((state == PRE) || (state == POST));
  end

  // NOTE: next state defaults to the current state before the case so no
  // path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (arm) state_nxt = PRE;
      PRE:     if (trig_ok) state_nxt = POST;
      POST:    if (post_end) state_nxt = READ;
      READ:    if (rd_fire && rd_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // NOTE: all sequential state uses non-blocking assignment so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done      <= 1'b0;
      trig_addr <= '0;
      fill_cnt  <= '0;
      post_cnt  <= '0;
      rd_cnt    <= '0;
      last_addr <= '0;
      rd_ptr    <= '0;
      mid_valid <= 1'b0;
      mid_last  <= 1'b0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
    end else begin
      done <= (state == READ) && rd_fire && rd_last;

      if ((state == IDLE) && arm) begin
        fill_cnt <= '0;
        post_cnt <= '0;
      end
      if ((state == PRE) && wren && (fill_cnt != DEPTH_C)) fill_cnt <= fill_cnt + 1'b1;
      if (trig_ok) trig_addr <= addrq;
      if ((state == POST) && wren) post_cnt <= post_cnt + 1'b1;

      if (post_end) begin
        last_addr <= addrq;
        rd_ptr    <= addrq + 1'b1;
        rd_cnt    <= '0;
      end

      if (issue) begin
        rd_ptr   <= rd_ptr + 1'b1;
        rd_cnt   <= rd_cnt + 1'b1;
        mid_last <= (rd_ptr == last_addr);
      end

      if (issue)         mid_valid <= 1'b1;
      else if (out_load) mid_valid <= 1'b0;

      if (out_load) begin
        rd_data  <= ram_q;
        rd_last  <= mid_last;
        rd_valid <= 1'b1;
      end else if (rd_fire) begin
        rd_valid <= 1'b0;
        rd_last  <= 1'b0;
      end
    end
  end

  capture_ram #(
    .BUS_WIDTH (BUS_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(addrq),
    .wdata(Q),
    .re   (issue),
    .raddr(rd_ptr),
    .rdata(ram_q)
  );

endmodule

// File: tb/tb_capture_buffer.sv
// Directed bench for capture_buffer: capture/trigger scenarios with a
// sample-memory model and a stream checker for order, timing and stalls.
module tb_capture_buffer;

  localparam int BW    = 1;
  localparam int AW    = 10;
  localparam int DEPTH = 1024;
  localparam int POST  = 512;

  logic          clk = 1'b0;
  logic          rst, arm, wren, trigger, rd_ready;
  logic [BW-1:0] q;
  logic [AW-1:0] addrq;
  logic          busy, done, rd_valid, rd_last;
  logic [AW-1:0] trig_addr;
  logic [BW-1:0] rd_data;

  capture_buffer #(
    .BUS_WIDTH (BW),
    .ADDR_WIDTH(AW),
    .POST_TRIG (POST)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .arm      (arm),
    .Q        (q),
    .addrq    (addrq),
    .wren     (wren),
    .trigger  (trigger),
    .busy     (busy),
    .done     (done),
    .trig_addr(trig_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_last  (rd_last)
  );

  always #5 clk = ~clk;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [BW-1:0] model [DEPTH];
  logic [BW-1:0] rx    [DEPTH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Arm, then feed sequential addresses from 0 up to trig_at + n_post,
  // raising trigger at trig_at (and at early_at if non-negative).
  task automatic capture(input int trig_at, input int early_at, input bit rnd_q,
                         input int n_post, input string tag);
    @(negedge clk);
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    check({tag, "_busy_after_arm"}, busy, 1);
    for (int a = 0; a <= trig_at + n_post; a++) begin
      @(negedge clk);
      addrq   = AW'(a % DEPTH);
      q       = rnd_q ? BW'($urandom) : BW'(a & 1);
      wren    = 1'b1;
      trigger = (a == trig_at) || (a == early_at);
      model[a % DEPTH] = q;
    end
  endtask

  // Consume the stream; returns after the done cycle or a cycle budget.
  task automatic read_stream(input bit rnd_ready, input bit junk, input int first_addr,
                             input string tag);
    int            beats = 0, data_errs = 0, last_errs = 0, stall_errs = 0;
    int            busy_errs = 0, spur_done = 0, gaps = 0;
    int            last_idx = -1, first_valid = -1, last_beat_cyc = -1;
    bit            prev_stall = 1'b0, done_next = 1'b0, got_done = 1'b0;
    logic [BW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;
    for (int cyc = 1; cyc <= 20000 && !got_done; cyc++) begin
      @(negedge clk);
      if (done_next) begin
        check({tag, "_done_pulse"}, done, 1);
        check({tag, "_busy_fall"}, busy, 0);
        check({tag, "_valid_after"}, rd_valid, 0);
        got_done = 1'b1;
      end else begin
        if (prev_stall && (rd_valid !== 1'b1 || rd_data !== prev_data || rd_last !== prev_last))
          stall_errs++;
        if (done) spur_done++;
        if (!busy) busy_errs++;
        wren     = junk;
        trigger  = junk;
        addrq    = AW'($urandom);
        q        = BW'($urandom);
        arm      = junk && (cyc == 5);
        rd_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (rd_valid && first_valid < 0) first_valid = cyc;
        if (rd_valid && rd_ready) begin
          if (beats < DEPTH) begin
            rx[beats] = rd_data;
            if (rd_data !== model[(first_addr + beats) % DEPTH]) data_errs++;
          end
          if (rd_last !== (beats == DEPTH - 1)) last_errs++;
          if (rd_last) begin
            last_idx  = beats;
            done_next = 1'b1;
          end
          if (last_beat_cyc >= 0 && cyc != last_beat_cyc + 1) gaps++;
          last_beat_cyc = cyc;
          beats++;
        end
        prev_stall = rd_valid && !rd_ready;
        prev_data  = rd_data;
        prev_last  = rd_last;
      end
    end
    wren = 1'b0; trigger = 1'b0; arm = 1'b0; rd_ready = 1'b0;
    check({tag, "_got_done"}, got_done, 1);
    check({tag, "_beats"}, beats, DEPTH);
    check({tag, "_data_errs"}, data_errs, 0);
    check({tag, "_last_errs"}, last_errs, 0);
    check({tag, "_last_idx"}, last_idx, DEPTH - 1);
    check({tag, "_stall_errs"}, stall_errs, 0);
    check({tag, "_busy_errs"}, busy_errs, 0);
    check({tag, "_spurious_done"}, spur_done, 0);
    if (!rnd_ready) begin
      check({tag, "_first_valid_cyc"}, first_valid, 3);
      check({tag, "_gaps"}, gaps, 0);
    end
    @(negedge clk);
    check({tag, "_done_one_cycle"}, done, 0);
    check({tag, "_stays_idle"}, busy, 0);
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; wren = 1'b0; trigger = 1'b0; rd_ready = 1'b0;
    q = '0; addrq = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_last", rd_last, 0);
    check("rst_data", rd_data, 0);
    check("rst_trig_addr", trig_addr, 0);
    rst = 1'b0;

    // wren/trigger in IDLE must not start anything
    @(negedge clk);
    wren = 1'b1; trigger = 1'b1; addrq = 10'd5;
    @(negedge clk);
    wren = 1'b0; trigger = 1'b0;
    @(negedge clk);
    check("idle_wren_busy", busy, 0);
    check("idle_wren_trig_addr", trig_addr, 0);

    // Basic capture at full rate: trigger 599, last write 87, read from 88
    capture(599, -1, 1'b0, POST, "basic");
    check("basic_trig_addr", trig_addr, 599);
    read_stream(1'b0, 1'b0, 88, "basic");

    // Early trigger at fill 100 ignored; accepted at 700; read from 189
    capture(700, 100, 1'b1, POST, "early");
    check("early_trig_addr", trig_addr, 700);
    read_stream(1'b0, 1'b0, 189, "early");
    check("early_trig_sample_idx511", rx[DEPTH - 1 - POST], model[700]);

    // Backpressure with random ready and random data
    capture(599, -1, 1'b1, POST, "bp");
    read_stream(1'b1, 1'b0, 88, "bp");

    // Reset 200 samples after the trigger, then re-arm
    capture(599, -1, 1'b0, 200, "mid");
    @(negedge clk);
    wren = 1'b0; trigger = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_valid", rd_valid, 0);
    check("midrst_trig_addr", trig_addr, 0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_no_done", done, 0);
    capture(599, -1, 1'b1, POST, "rearm");
    check("rearm_trig_addr", trig_addr, 599);
    read_stream(1'b0, 1'b0, 88, "rearm");

    // arm, wren and trigger driven throughout READ are ignored
    capture(599, -1, 1'b1, POST, "junk");
    read_stream(1'b0, 1'b1, 88, "junk");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
